varint_decode_fsm: RTL and testbench

VARINT_DECODE_FSM -- requirements
Module: varint_decode_fsm

---
 rtl/varint_decode_fsm.sv | 99 +++++++++
 tb/tb_varint_decode_fsm.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/varint_decode_fsm.sv
// Decodes one LEB128-style varint at a time from a show-ahead byte FIFO.
// Each byte carries 7 payload bits, least-significant group first. Bit 7 set
// means more bytes follow. The result is held until downstream accepts it.
// A tenth byte with its continuation bit set is an overflow. That error is
// sticky until reset.
module varint_decode_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        varint_enable,
  input  logic        in_fifo_empty,
  input  logic [7:0]  in_fifo_q,
  input  logic [9:0]  in_index_q,
  output logic        in_fifo_pop,
  output logic [63:0] varint_out_q,
  output logic [9:0]  varint_out_index_q,
  output logic        varint_data_valid,
  input  logic        varint_data_accepted,
  output logic        varint_err
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    READ  = 4'b0010,
    HOLD  = 4'b0100,
    ERROR = 4'b1000
  } state_t;

  state_t      state;
  logic [3:0]  byte_cnt;
  logic [63:0] acc;
  logic [5:0]  shamt;
  logic [63:0] byte_bits;
  logic [63:0] merged;

  // Payload group k lands at bit 7k. For k=9 the shift is 63, so only bit 0
  // of the payload survives the 64-bit truncation and bits 6:1 fall off.
  assign shamt     = 6'(7 * byte_cnt);
  assign byte_bits = 64'(in_fifo_q[6:0]) << shamt;
  // Byte 0 loads rather than ORs, so no residue from an earlier varint leaks in.
  assign merged    = (byte_cnt == 4'd0) ? byte_bits : (acc | byte_bits);

  // The pop has to be combinational. The FIFO is show-ahead, so the byte is
  // consumed in the same cycle it is examined. Reset blocks it outright.
  assign in_fifo_pop = (state == READ) && !in_fifo_empty && !reset;

  // Main FSM, holding the accumulator, the result and the flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      byte_cnt           <= 4'd0;
      acc                <= 64'd0;
      varint_out_q       <= 64'd0;
      varint_out_index_q <= 10'd0;
      varint_data_valid  <= 1'b0;
      varint_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (varint_enable) state <= READ;
        end
        READ: begin
          if (!in_fifo_empty) begin
            if (byte_cnt == 4'd0) varint_out_index_q <= in_index_q;
            if (!in_fifo_q[7]) begin
              varint_out_q      <= merged;
              acc               <= merged;
              varint_data_valid <= 1'b1;
              byte_cnt          <= 4'd0;
              state             <= HOLD;
            end else if (byte_cnt == 4'd9) begin
              varint_err <= 1'b1;
              byte_cnt   <= 4'd0;
              state      <= ERROR;
            end else begin
              acc      <= merged;
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (varint_data_accepted) begin
            varint_data_valid <= 1'b0;
            state             <= IDLE;
          end
        end
        ERROR: begin
          varint_err        <= 1'b1;
          varint_data_valid <= 1'b0;
        end
        default: begin
          state             <= IDLE;
          byte_cnt          <= 4'd0;
          varint_data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_varint_decode_fsm.sv
// Directed bench for varint_decode_fsm. A behavioural show-ahead FIFO feeds
// the decoder. Expected values are computed by hand from the byte sequences.
module tb_varint_decode_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        varint_enable;
  logic        in_fifo_empty;
  logic [7:0]  in_fifo_q;
  logic [9:0]  in_index_q;
  logic        in_fifo_pop;
  logic [63:0] varint_out_q;
  logic [9:0]  varint_out_index_q;
  logic        varint_data_valid;
  logic        varint_data_accepted;
  logic        varint_err;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural FIFO plus pop bookkeeping.
  logic [7:0] mem_b [0:63];
  logic [9:0] mem_i [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  bit fifo_clr = 0;

  assign in_fifo_empty = (rd_ptr == wr_ptr);
  assign in_fifo_q     = mem_b[rd_ptr[5:0]];
  assign in_index_q    = mem_i[rd_ptr[5:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (in_fifo_pop) begin
      rd_ptr       <= rd_ptr + 1;
      pop_cnt      <= pop_cnt + 1;
      last_pop_cyc <= cyc;
    end
  end

  varint_decode_fsm dut (
    .clk(clk), .reset(reset), .varint_enable(varint_enable),
    .in_fifo_empty(in_fifo_empty), .in_fifo_q(in_fifo_q), .in_index_q(in_index_q),
    .in_fifo_pop(in_fifo_pop), .varint_out_q(varint_out_q),
    .varint_out_index_q(varint_out_index_q), .varint_data_valid(varint_data_valid),
    .varint_data_accepted(varint_data_accepted), .varint_err(varint_err)
  );

  task automatic push(input logic [7:0] b, input logic [9:0] idx);
    mem_b[wr_ptr[5:0]] = b;
    mem_i[wr_ptr[5:0]] = idx;
    wr_ptr = wr_ptr + 1;
  endtask

  // Pulses varint_enable for one cycle. The caller is at a negedge.
  task automatic start();
    varint_enable = 1'b1;
    @(negedge clk);
    varint_enable = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (varint_data_valid) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    varint_data_accepted = 1'b1;
    @(negedge clk);
    varint_data_accepted = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; varint_enable = 1'b0; varint_data_accepted = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (varint_data_valid !== 1'b0 || varint_err !== 1'b0 || in_fifo_pop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: valid=%b err=%b pop=%b, want 0/0/0", varint_data_valid, varint_err, in_fifo_pop);
    end
    vectors++;
    if (varint_out_q !== 64'd0 || varint_out_index_q !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: out=%h idx=%0d, want 0/0", varint_out_q, varint_out_index_q);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_byte();
    int p0;
    p0 = pop_cnt;
    push(8'h01, 10'd3);
    vectors++;
    if (in_fifo_pop !== 1'b0) begin
      miscompares++; $display("FAIL idle_no_pop: pop=%b, want 0", in_fifo_pop);
    end
    start();
    vectors++;
    if (in_fifo_pop !== 1'b1) begin
      miscompares++; $display("FAIL one_pop_asserted: pop=%b, want 1", in_fifo_pop);
    end
    @(negedge clk);
    vectors++;
    if (varint_data_valid !== 1'b1 || varint_out_q !== 64'h1 || varint_out_index_q !== 10'd3) begin
      miscompares++;
      $display("FAIL one_byte: valid=%b out=%h idx=%0d, want 1/1/3", varint_data_valid, varint_out_q, varint_out_index_q);
    end
    vectors++;
    if (cyc - last_pop_cyc !== 1 || pop_cnt - p0 !== 1) begin
      miscompares++;
      $display("FAIL one_latency: lat=%0d pops=%0d, want 1/1", cyc - last_pop_cyc, pop_cnt - p0);
    end
    accept();
    vectors++;
    if (varint_data_valid !== 1'b0) begin
      miscompares++; $display("FAIL one_accept: valid=%b, want 0", varint_data_valid);
    end
  endtask

  task automatic test_two_byte();
    int p0; bit ok;
    p0 = pop_cnt;
    push(8'hAC, 10'd7); push(8'h02, 10'd7);
    start();
    wait_valid(20, ok);
    vectors++;
    if (!ok || varint_out_q !== 64'h12C || varint_out_index_q !== 10'd7) begin
      miscompares++;
      $display("FAIL two_byte: ok=%0d out=%h idx=%0d, want 1/12c/7", ok, varint_out_q, varint_out_index_q);
    end
    vectors++;
    if (pop_cnt - p0 !== 2 || cyc - last_pop_cyc !== 1) begin
      miscompares++;
      $display("FAIL two_pops: pops=%0d lat=%0d, want 2/1", pop_cnt - p0, cyc - last_pop_cyc);
    end
    accept();
  endtask

  task automatic test_ten_byte();
    int p0; bit ok;
    p0 = pop_cnt;
    for (int i = 0; i < 9; i++) push(8'hFF, 10'd12);
    push(8'h7F, 10'd12);
    start();
    wait_valid(30, ok);
    vectors++;
    if (!ok || varint_out_q !== 64'hFFFF_FFFF_FFFF_FFFF || varint_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ten_byte: ok=%0d out=%h err=%b, want 1/ffffffffffffffff/0", ok, varint_out_q, varint_err);
    end
    vectors++;
    if (pop_cnt - p0 !== 10 || varint_out_index_q !== 10'd12) begin
      miscompares++;
      $display("FAIL ten_pops: pops=%0d idx=%0d, want 10/12", pop_cnt - p0, varint_out_index_q);
    end
    accept();
  endtask

  task automatic test_stall_hold();
    int p0; int p1; bit ok; bit got;
    p0 = pop_cnt;
    push(8'h96, 10'd5);
    start();
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (pop_cnt - p0 == 1) got = 1; else @(negedge clk);
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL stall_first_pop: pops=%0d, want 1", pop_cnt - p0); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (in_fifo_pop !== 1'b0 || varint_data_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_empty: pop=%b valid=%b, want 0/0", in_fifo_pop, varint_data_valid);
      end
      @(negedge clk);
    end
    push(8'h01, 10'd6);
    wait_valid(10, ok);
    vectors++;
    if (!ok || varint_out_q !== 64'd150 || varint_out_index_q !== 10'd5 || pop_cnt - p0 !== 2) begin
      miscompares++;
      $display("FAIL stall_result: ok=%0d out=%0d idx=%0d pops=%0d, want 1/150/5/2", ok, varint_out_q, varint_out_index_q, pop_cnt - p0);
    end
    // Queue a byte so an unwanted pop during HOLD would be visible.
    push(8'h01, 10'd8);
    p1 = pop_cnt;
    varint_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (varint_data_valid !== 1'b1 || varint_out_q !== 64'd150 || varint_out_index_q !== 10'd5 ||
          in_fifo_pop !== 1'b0 || pop_cnt !== p1) begin
        miscompares++;
        $display("FAIL hold_stable: valid=%b out=%0d idx=%0d pop=%b, want 1/150/5/0", varint_data_valid, varint_out_q, varint_out_index_q, in_fifo_pop);
      end
    end
    varint_enable = 1'b0;
    accept();
    fifo_clr = 1'b1; @(negedge clk); fifo_clr = 1'b0;
  endtask

  task automatic test_overflow();
    int p0; bit got;
    p0 = pop_cnt;
    for (int i = 0; i < 10; i++) push(8'h80, 10'd1);
    push(8'h01, 10'd1); push(8'h01, 10'd1);
    start();
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (varint_err) got = 1; else @(negedge clk);
    end
    vectors++;
    if (!got || pop_cnt - p0 !== 10 || varint_data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow: err_seen=%0d pops=%0d valid=%b, want 1/10/0", got, pop_cnt - p0, varint_data_valid);
    end
    varint_enable = 1'b1;
    repeat (5) @(negedge clk);
    varint_enable = 1'b0;
    vectors++;
    if (pop_cnt - p0 !== 10 || varint_err !== 1'b1 || varint_data_valid !== 1'b0 || in_fifo_pop !== 1'b0) begin
      miscompares++;
      $display("FAIL error_absorbing: pops=%0d err=%b valid=%b pop=%b, want 10/1/0/0", pop_cnt - p0, varint_err, varint_data_valid, in_fifo_pop);
    end
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    fifo_clr = 1'b1; @(negedge clk); fifo_clr = 1'b0;
    vectors++;
    if (varint_err !== 1'b0 || varint_data_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_reset: err=%b valid=%b, want 0/0", varint_err, varint_data_valid);
    end
  endtask

  task automatic test_reset_mid();
    int p0; bit got; bit ok;
    p0 = pop_cnt;
    push(8'hFF, 10'd2);
    start();
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (pop_cnt - p0 == 1) got = 1; else @(negedge clk);
    end
    // The decoder is mid-varint in READ. Making data available during reset
    // must not cause a pop.
    reset = 1'b1;
    push(8'h05, 10'd9);
    #1;
    vectors++;
    if (!got || in_fifo_pop !== 1'b0) begin
      miscompares++; $display("FAIL reset_no_pop: popped=%0d pop=%b, want 1/0", got, in_fifo_pop);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_fifo_pop !== 1'b0 || varint_data_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_to_idle: pop=%b valid=%b, want 0/0", in_fifo_pop, varint_data_valid);
    end
    start();
    wait_valid(10, ok);
    vectors++;
    if (!ok || varint_out_q !== 64'h5 || varint_out_index_q !== 10'd9) begin
      miscompares++;
      $display("FAIL no_residue: ok=%0d out=%h idx=%0d, want 1/5/9", ok, varint_out_q, varint_out_index_q);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_two_byte();
    test_ten_byte();
    test_stall_hold();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
